// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle sequencing controller for the RV32I core: walks one instruction at a time
// through fetch, decode, execute, memory and write-back, driving every datapath strobe.
module riscv_mc_ctrl #(
  parameter bit RESET_RUN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_dst_reg_addr,
  input  logic        i_br_taken,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_ir_we,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_mdr_we,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic [2:0]  o_state,
  output logic        o_illegal,
  output logic [31:0] o_instret
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t      state, next_state;
  logic [6:0]  op_q;
  logic [4:0]  rd_q;
  logic        req_pend;
  logic        illegal_q;
  logic [31:0] instret_q;
  logic        retire;
  logic        fetch_go;
  logic        opcode_legal;

  logic is_load, is_store, is_branch, is_jal, is_jalr;
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);

  always_comb begin
    case (i_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_ALUI, OP_ALUR: opcode_legal = 1'b1;
      default:                             opcode_legal = 1'b0;
    endcase
  end

  // Once a fetch request is up it stays up until acked, regardless of i_run.
  // Reset gating makes the request drop the moment reset asserts.
  assign fetch_go = (i_run || req_pend) && !i_rst;

  // NOTE: every output and next_state gets a default before the case, so no
  // path through this block can leave a value unassigned and infer a latch.
  always_comb begin
    next_state = state;
    o_imem_req = 1'b0;
    o_ir_we    = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_mdr_we   = 1'b0;
    o_rf_we    = 1'b0;
    o_wb_sel   = 2'd0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 2'd0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_go) begin
          o_imem_req = 1'b1;
          if (i_imem_ack) begin
            o_ir_we    = 1'b1;
            next_state = S_DECODE;
          end
        end
      end
      S_DECODE: next_state = opcode_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_load || is_store) begin
          next_state = S_MEM;
        end else if (is_branch) begin
          o_pc_we    = 1'b1;
          o_pc_sel   = i_br_taken ? 2'd1 : 2'd0;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = is_store;
        if (i_dmem_ack) begin
          if (is_store) begin
            o_pc_we    = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            o_mdr_we   = 1'b1;
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        o_rf_we    = (rd_q != 5'd0);
        o_wb_sel   = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        o_pc_we    = 1'b1;
        o_pc_sel   = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_FETCH;
      op_q      <= 7'd0;
      rd_q      <= 5'd0;
      req_pend  <= RESET_RUN;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q <= i_opcode;
        rd_q <= i_dst_reg_addr;
      end
      if (state == S_FETCH) req_pend <= o_imem_req && !i_imem_ack;
      if (next_state == S_TRAP) illegal_q <= 1'b1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign o_state   = state;
  assign o_illegal = illegal_q;
  assign o_instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Self-checking bench for riscv_mc_ctrl: an instruction-level model expands each directed
// instruction into its expected per-cycle output schedule, checked every cycle.
module tb_riscv_mc_ctrl;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, br_taken, imem_ack, dmem_ack;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        imem_req, ir_we, dmem_req, dmem_we, mdr_we, rf_we, pc_we, illegal;
  logic [1:0]  wb_sel, pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.RESET_RUN(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_opcode(opcode),
    .i_dst_reg_addr(rd), .i_br_taken(br_taken),
    .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
    .o_imem_req(imem_req), .o_ir_we(ir_we), .o_dmem_req(dmem_req),
    .o_dmem_we(dmem_we), .o_mdr_we(mdr_we), .o_rf_we(rf_we),
    .o_wb_sel(wb_sel), .o_pc_we(pc_we), .o_pc_sel(pc_sel),
    .o_state(state), .o_illegal(illegal), .o_instret(instret)
  );

  // One cycle of stimulus plus the outputs the rules require in that cycle.
  typedef struct packed {
    logic        run, iack, dack, taken;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  st;
    logic        imem_req, ir_we, dmem_req, dmem_we, mdr_we, rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic [31:0] instret;
  } ent_t;

  int    checks = 0;
  int    errors = 0;
  int    model_ret = 0;
  int    cyc = 0;
  ent_t  cur;
  bit    cur_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Single compare process: every driven cycle is checked mid-cycle.
  always @(negedge clk) begin
    if (cur_valid) begin
      logic [63:0] g, x;
      g = {17'd0, state, imem_req, ir_we, dmem_req, dmem_we, mdr_we, rf_we,
           wb_sel, pc_we, pc_sel, illegal, instret};
      x = {17'd0, cur.st, cur.imem_req, cur.ir_we, cur.dmem_req, cur.dmem_we,
           cur.mdr_we, cur.rf_we, cur.wb_sel, cur.pc_we, cur.pc_sel,
           cur.illegal, cur.instret};
      check($sformatf("cycle%0d_state%0d", cyc, cur.st), g, x);
    end
  end

  function automatic ent_t blank(input logic [2:0] st, input logic taken);
    ent_t e;
    e       = '0;
    e.st    = st;
    e.op    = 7'h7F;
    e.rd    = 5'h1F;
    e.taken = ~taken;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    @(posedge clk);
    #1;
    run      = e.run;
    imem_ack = e.iack;
    dmem_ack = e.dack;
    br_taken = e.taken;
    opcode   = e.op;
    rd       = e.rd;
    cur       = e;
    cur_valid = 1'b1;
    cyc++;
  endtask

  task automatic finish_seq();
    @(negedge clk);
    #1;
    cur_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ent_t e;
    for (int k = 0; k < n; k++) begin
      e         = blank(3'd0, 1'b0);
      e.iack    = k[0];
      e.instret = model_ret;
      drive(e);
    end
    finish_seq();
  endtask

  // Expands one instruction into its cycle schedule. iwait/dwait are memory
  // wait cycles before the ack; max_cyc > 0 cuts the instruction short.
  task automatic run_instr(input logic [6:0] op, input logic [4:0] rdv, input logic taken,
                           input int iwait, input int dwait, input int max_cyc,
                           output int ncyc);
    ent_t q[$];
    ent_t e;
    bit ld, st, br, jal, jalr, legal, retire;
    ld = (op == OP_LOAD); st = (op == OP_STORE); br = (op == OP_BRANCH);
    jal = (op == OP_JAL); jalr = (op == OP_JALR);
    legal = ld || st || br || jal || jalr || op == OP_LUI || op == OP_AUIPC ||
            op == OP_ALUI || op == OP_ALUR;
    retire = 1'b0;
    for (int i = 0; i <= iwait; i++) begin
      e = blank(3'd0, taken);
      e.run = (i == 0);
      e.imem_req = 1'b1;
      if (i == iwait) begin e.iack = 1'b1; e.ir_we = 1'b1; end
      q.push_back(e);
    end
    e = blank(3'd1, taken);
    e.op = op; e.rd = rdv; e.dack = 1'b1;
    q.push_back(e);
    if (!legal) begin
      for (int j = 0; j < 20; j++) begin
        e = blank(3'd5, taken);
        e.illegal = 1'b1; e.run = 1'b1; e.iack = j[0]; e.dack = !j[0];
        q.push_back(e);
      end
    end else begin
      e = blank(3'd2, taken);
      e.taken = taken; e.iack = 1'b1;
      if (br) begin e.pc_we = 1'b1; e.pc_sel = {1'b0, taken}; retire = 1'b1; end
      q.push_back(e);
      if (ld || st) begin
        for (int i = 0; i <= dwait; i++) begin
          e = blank(3'd3, taken);
          e.dmem_req = 1'b1; e.dmem_we = st; e.iack = 1'b1;
          if (i == dwait) begin
            e.dack = 1'b1;
            if (st) begin e.pc_we = 1'b1; retire = 1'b1; end
            else e.mdr_we = 1'b1;
          end
          q.push_back(e);
        end
      end
      if (!br && !st) begin
        e = blank(3'd4, taken);
        e.rf_we  = (rdv != 5'd0);
        e.wb_sel = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        e.pc_we  = 1'b1;
        e.pc_sel = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
        retire   = 1'b1;
        q.push_back(e);
      end
    end
    if (max_cyc > 0 && q.size() > max_cyc) begin
      while (q.size() > max_cyc) void'(q.pop_back());
      retire = 1'b0;
    end
    foreach (q[k]) begin
      e = q[k];
      e.instret = model_ret;
      drive(e);
    end
    finish_seq();
    ncyc = q.size();
    if (retire) model_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    opcode = 7'd0; rd = 5'd0;
    #8;
    check("rst_state",    {61'd0, state}, 64'd0);
    check("rst_imem_req", {63'd0, imem_req}, 64'd0);
    check("rst_instret",  {32'd0, instret}, 64'd0);
    check("rst_illegal",  {63'd0, illegal}, 64'd0);
    check("rst_sels",     {60'd0, wb_sel, pc_sel}, 64'd0);
    #4 rst = 1'b0;

    idle(10);
    run_instr(OP_ALUR, 5'd5, 1'b0, 0, 0, 0, n);
    check("lat_alu", n, 4);
    idle(1);
    check("instret_after_alu", {32'd0, instret}, 64'd1);
    run_instr(OP_ALUR, 5'd0, 1'b0, 2, 0, 0, n);
    run_instr(OP_LOAD, 5'd9, 1'b0, 0, 2, 0, n);
    check("lat_load_2wait", n, 7);
    run_instr(OP_STORE, 5'd3, 1'b1, 0, 0, 0, n);
    check("lat_store", n, 4);
    run_instr(OP_BRANCH, 5'd0, 1'b1, 0, 0, 0, n);
    check("lat_branch", n, 3);
    run_instr(OP_BRANCH, 5'd0, 1'b0, 1, 0, 0, n);
    run_instr(OP_JAL, 5'd1, 1'b0, 0, 0, 0, n);
    run_instr(OP_JALR, 5'd3, 1'b1, 0, 0, 0, n);
    run_instr(OP_LUI, 5'd31, 1'b0, 0, 0, 0, n);
    run_instr(OP_AUIPC, 5'd2, 1'b0, 0, 0, 0, n);
    run_instr(OP_ALUI, 5'd4, 1'b1, 0, 0, 0, n);
    run_instr(OP_STORE, 5'd0, 1'b0, 1, 3, 0, n);
    run_instr(OP_LOAD, 5'd0, 1'b1, 0, 0, 0, n);
    check("lat_load_0wait", n, 5);
    idle(2);

    // Abort a load while its data request is still waiting for an ack.
    run_instr(OP_LOAD, 5'd7, 1'b0, 0, 5, 5, n);
    check("pre_rst_dmem_req", {63'd0, dmem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    check("mid_rst_state",    {61'd0, state}, 64'd0);
    check("mid_rst_instret",  {32'd0, instret}, 64'd0);
    check("mid_rst_illegal",  {63'd0, illegal}, 64'd0);
    @(posedge clk);
    #1;
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; rst = 1'b0;
    model_ret = 0;
    idle(3);
    run_instr(OP_ALUR, 5'd6, 1'b0, 0, 0, 0, n);

    run_instr(7'h7F, 5'd8, 1'b0, 0, 0, 0, n);
    check("trap_illegal", {63'd0, illegal}, 64'd1);
    check("trap_state",   {61'd0, state}, 64'd5);
    rst = 1'b1;
    #1;
    check("trap_rst_illegal", {63'd0, illegal}, 64'd0);
    check("trap_rst_state",   {61'd0, state}, 64'd0);
    #10 rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
# riscv_mc_ctrl

Multi-cycle sequencing controller for the RV32I core. Drives the fetch, decode, execute, memory and write-back steps of one instruction at a time around the shared datapath: instruction register, ID stage, ALU, register file and PC. It consumes the ID stage's decoded control fields and the ALU branch result. It produces every datapath write-enable, mux select and memory request, and counts retired instructions.

## Interface
Parameters:
- RESET_RUN, 1, when 1 the controller starts fetching immediately after reset; when 0 it waits for i_run.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_run  in  1  fetch enable; sampled only in FETCH before a request is issued
- i_opcode  in  7  opcode field from the ID stage
- i_dst_reg_addr  in  5  rd field from the ID stage
- i_br_taken  in  1  ALU branch-condition result, valid in EXEC
- i_imem_ack  in  1  instruction memory ack; data valid in the same cycle
- i_dmem_ack  in  1  data memory ack; load data valid in the same cycle
- o_imem_req  out  1  instruction fetch request
- o_ir_we  out  1  instruction register load
- o_dmem_req  out  1  data memory request
- o_dmem_we  out  1  data memory write (store); valid only with o_dmem_req
- o_mdr_we  out  1  load-data register capture
- o_rf_we  out  1  register file write
- o_wb_sel  out  2  write-back select: 0 = ALU, 1 = load data, 2 = PC+4
- o_pc_we  out  1  PC update
- o_pc_sel  out  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR)
- o_state  out  3  current state encoding
- o_illegal  out  1  sticky illegal-opcode flag
- o_instret  out  32  retired-instruction counter

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5. Unused encodings go to FETCH on the next edge.
- FETCH:
  - Idle while i_run=0 and no request is outstanding.
  - Otherwise o_imem_req=1, held until i_imem_ack. i_run is ignored once the request is raised.
  - In the ack cycle, o_ir_we=1 and next state is DECODE.
- DECODE:
  - Latches i_opcode and i_dst_reg_addr into internal registers.
  - Opcode is one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ALU-imm, ALU-reg: next state EXEC.
  - Any other opcode: next state TRAP.
- EXEC, one cycle, actions by latched opcode:
  - LOAD or STORE: next state MEM.
  - BRANCH: o_pc_we=1; o_pc_sel=1 if i_br_taken, else 0; next state FETCH; retire.
  - All others: next state WB.
- MEM:
  - o_dmem_req=1, and o_dmem_we=1 for STORE; both held until i_dmem_ack.
  - On ack for STORE: o_pc_we=1, o_pc_sel=0, next state FETCH, retire.
  - On ack for LOAD: o_mdr_we=1, next state WB.
- WB:
  - o_rf_we=1 unless the latched rd is 0.
  - o_wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - o_pc_we=1; o_pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - Next state FETCH; retire.
- TRAP: o_illegal=1. No strobes or requests. Leaves TRAP only on reset.
- Retire: o_instret increments by 1 on the state-leaving edge and wraps from 0xFFFFFFFF to 0.
- Strobes: all write-enables and requests are 0 in every state/condition not listed above.
- Ack handling: an ack with no corresponding request is ignored. i_imem_ack and i_dmem_ack are never both meaningful in the same state.

## Timing
- Reset values: state FETCH; o_illegal 0; o_instret 0; all strobes/requests 0; o_wb_sel 0; o_pc_sel 0. Outputs derived from state are 0 during reset.
- First request after reset release:
  - RESET_RUN=1: o_imem_req=1 in the first cycle after reset deasserts.
  - RESET_RUN=0: o_imem_req=1 in the cycle i_run is seen high.
- All outputs except o_state, o_illegal and o_instret are combinational from state, latched opcode/rd, acks and i_br_taken.
- Zero-wait memory (ack in the first request cycle), latency in cycles including FETCH:
  - ALU, LUI, AUIPC, JAL, JALR: 4
  - BRANCH: 3
  - STORE: 4
  - LOAD: 5
- Each memory wait cycle adds one cycle. The request stays high, and o_dmem_we stays stable, through every wait cycle.
- Reset asserted mid-operation, including during an outstanding request: immediate return to reset values. The request drops asynchronously and is not retried.

## Test plan
- Reset/idle: RESET_RUN=0, i_run=0 for 10 cycles -> o_state=0, o_imem_req=0, o_instret=0. Then i_run=1 -> o_imem_req=1 in the same cycle.
- ALU-reg, rd=5, zero-wait imem -> state sequence 0,1,2,4. In WB: o_rf_we=1, o_wb_sel=0, o_pc_we=1, o_pc_sel=0. o_instret becomes 1. Repeat with rd=0 -> o_rf_we=0.
- LOAD, dmem ack after 2 wait cycles -> o_dmem_req high 3 cycles with o_dmem_we=0; o_mdr_we=1 on the ack cycle; WB with o_wb_sel=1; 7 cycles total.
- STORE, zero-wait -> o_dmem_req=1 and o_dmem_we=1 in MEM; o_pc_we=1, o_pc_sel=0 on ack; no WB state; o_rf_we never 1.
- BRANCH taken then not taken -> EXEC cycle shows o_pc_sel=1, then o_pc_sel=0, each with o_pc_we=1. JAL rd=1 -> WB with o_wb_sel=2, o_pc_sel=1. JALR -> o_pc_sel=2.
- Illegal opcode 0x7F -> DECODE then TRAP; o_illegal=1 held 20 cycles; no requests. Reset asserted during an outstanding dmem request -> o_dmem_req=0 immediately, o_illegal=0, o_instret=0.
